regfile_write_scheduler: RTL and testbench

Sequencer and arbiter for the single write port of the 8x8 register file (register_file_8x8). It shares the write port between two requesters using valid/ready handshakes and round-robin priority. It also provides a hardware clear sequence that writes 0x00 to all eight registers. Its outputs connect directly to the register file's we/waddr/wdata inputs; the read ports are not touched.

---
 rtl/regfile_write_scheduler.sv | 120 ++++++++++++
 tb/tb_regfile_write_scheduler.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_scheduler.sv
// Write-port sequencer for the 8x8 register file:
// round-robin arbitration of two requesters plus a hardware clear walk.
module regfile_write_scheduler #(
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              clear_start,
  output logic              busy,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [7:0]        collisions
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  state_t            state_q, state_d;
  logic              prio_q, prio_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        coll_q, coll_d;

  // State, priority, pointer, write-port and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      ptr_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      coll_q  <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      coll_q  <= coll_d;
    end
  end

  // Next state, grants and next write-port contents
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    ptr_d      = ptr_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    coll_d     = coll_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end else begin
          req0_ready = req0_valid &
                       (~req1_valid | ~prio_q);
          req1_ready = req1_valid &
                       (~req0_valid | prio_q);
          if (req0_ready) begin
            we_d    = 1'b1;
            waddr_d = req0_addr;
            wdata_d = req0_data;
            prio_d  = 1'b1;
          end else if (req1_ready) begin
            we_d    = 1'b1;
            waddr_d = req1_addr;
            wdata_d = req1_data;
            prio_d  = 1'b0;
          end
          if (req0_valid && req1_valid &&
              coll_q != 8'hFF)
            coll_d = coll_q + 8'd1;
        end
      end
      CLEAR: begin
        we_d    = 1'b1;
        waddr_d = ptr_q;
        wdata_d = '0;
        if (ptr_q == LAST) begin
          ptr_d   = '0;
          state_d = IDLE;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q == CLEAR);
  assign rf_we      = we_q;
  assign rf_waddr   = waddr_q;
  assign rf_wdata   = wdata_q;
  assign collisions = coll_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Bench for regfile_write_scheduler: expected writes queued by stimulus,
// checked by a monitor that also keeps a shadow copy of the register file.
module tb_regfile_write_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [2:0] req0_addr, req1_addr;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       clear_start, busy, rf_we;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata, collisions;

  int errors = 0;
  int checks = 0;
  logic [10:0] exp_q[$];
  logic [7:0]  mem [8];

  always #5 clk = ~clk;

  regfile_write_scheduler dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr),
    .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr),
    .req1_data(req1_data), .req1_ready(req1_ready),
    .clear_start(clear_start), .busy(busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .collisions(collisions)
  );

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(logic [2:0] a, logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  // Scoreboard monitor: every register-file write must match the queue head
  always @(negedge clk) begin
    if (!reset && rf_we) begin
      if (exp_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_write: got addr=%0d data=%0h expected none",
                 rf_waddr, rf_wdata);
      end else begin
        chk("rf_write", int'({rf_waddr, rf_wdata}),
            int'(exp_q.pop_front()));
      end
      mem[rf_waddr] = rf_wdata;
    end
  end

  task automatic preload_ff();
    for (int i = 0; i < 8; i++) begin
      req0_valid = 1'b1;
      req0_addr  = 3'(i);
      req0_data  = 8'hFF;
      #1;
      chk("preload_ready", int'(req0_ready), 1);
      push(3'(i), 8'hFF);
      tick();
    end
    req0_valid = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_addr = '0; req1_addr = '0;
    req0_data = '0; req1_data = '0;
    clear_start = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 8'hA5;
    tick();
    tick();
    chk("rst_we", int'(rf_we), 0);
    chk("rst_waddr", int'(rf_waddr), 0);
    chk("rst_wdata", int'(rf_wdata), 0);
    chk("rst_coll", int'(collisions), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b0;
    tick();

    // Single request from requester 0
    req0_valid = 1'b1; req0_addr = 3'd5; req0_data = 8'h55;
    #1;
    chk("t1_ready0", int'(req0_ready), 1);
    chk("t1_ready1", int'(req1_ready), 0);
    push(3'd5, 8'h55);
    tick();
    req0_valid = 1'b0;
    tick();
    chk("t1_mem5", int'(mem[5]), 8'h55);

    // Requester 1 alone, leaves prio at 0
    req1_valid = 1'b1; req1_addr = 3'd7; req1_data = 8'h77;
    #1;
    chk("t2_solo1", int'(req1_ready), 1);
    push(3'd7, 8'h77);
    tick();
    req1_valid = 1'b0;

    // Both valid for 4 cycles: grants 0,1,0,1
    req0_addr = 3'd1; req0_data = 8'h11;
    req1_addr = 3'd2; req1_data = 8'h22;
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      chk("t2_ready0", int'(req0_ready), (i % 2 == 0) ? 1 : 0);
      chk("t2_ready1", int'(req1_ready), (i % 2 == 1) ? 1 : 0);
      if (i % 2 == 0) push(3'd1, req0_data);
      else            push(3'd2, req1_data);
      tick();
      if (i % 2 == 0) req0_data = req0_data + 8'd1;
      else            req1_data = req1_data + 8'd1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("t2_coll", int'(collisions), 4);
    tick();
    chk("t2_mem1", int'(mem[1]), 8'h12);
    chk("t2_mem2", int'(mem[2]), 8'h23);

    // Preload then clear; a mid-sequence clear_start is ignored
    preload_ff();
    clear_start = 1'b1;
    #1;
    chk("t3_busy_pre", int'(busy), 0);
    for (int i = 0; i < 8; i++) push(3'(i), 8'h00);
    tick();
    for (int j = 0; j < 8; j++) begin
      chk("t3_busy", int'(busy), 1);
      clear_start = (j == 5);
      tick();
    end
    clear_start = 1'b0;
    chk("t3_busy_end", int'(busy), 0);
    tick();
    tick();
    for (int i = 0; i < 8; i++)
      chk("t3_mem", int'(mem[i]), 0);

    // Clear wins over a simultaneous request
    clear_start = 1'b1;
    req1_valid = 1'b1; req1_addr = 3'd3; req1_data = 8'h33;
    #1;
    chk("t4_ready_start", int'(req1_ready), 0);
    for (int i = 0; i < 8; i++) push(3'(i), 8'h00);
    tick();
    clear_start = 1'b0;
    for (int j = 0; j < 8; j++) begin
      chk("t4_ready_clear", int'(req1_ready), 0);
      tick();
    end
    chk("t4_ready_idle", int'(req1_ready), 1);
    push(3'd3, 8'h33);
    tick();
    req1_valid = 1'b0;
    tick();
    tick();
    chk("t4_mem3", int'(mem[3]), 8'h33);

    // Reset while ptr=3 aborts the clear
    preload_ff();
    clear_start = 1'b1;
    for (int i = 0; i < 3; i++) push(3'(i), 8'h00);
    tick();
    clear_start = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("t5_we", int'(rf_we), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_waddr", int'(rf_waddr), 0);
    chk("t5_coll", int'(collisions), 0);
    tick();
    reset = 1'b0;
    tick();
    chk("t5_busy_after", int'(busy), 0);
    for (int i = 0; i < 8; i++)
      chk("t5_mem", int'(mem[i]), (i < 3) ? 0 : 8'hFF);

    // Long collision run: counter saturates at 255
    req0_valid = 1'b1; req0_addr = 3'd4; req0_data = 8'h44;
    req1_valid = 1'b1; req1_addr = 3'd6; req1_data = 8'h66;
    for (int i = 0; i < 300; i++) begin
      if (i < 4) begin
        #1;
        chk("t6_ready0", int'(req0_ready), (i % 2 == 0) ? 1 : 0);
      end
      if (i % 2 == 0) push(3'd4, 8'h44);
      else            push(3'd6, 8'h66);
      tick();
      if (i == 199) chk("t6_coll200", int'(collisions), 200);
      if (i == 254) chk("t6_coll255", int'(collisions), 255);
    end
    chk("t6_coll_sat", int'(collisions), 255);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    tick();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
